// File: rtl/pc_redirect_unit.sv
// -----------------------------------------------------------------------------
// pc_redirect_unit
//
// Owns the architectural fetch PC. It issues one instruction fetch at a time on
// the instruction bus and presents completed fetches to the IF/ID register. A
// redirect from the memory-stage branch check squashes all younger work and
// restarts fetch at the resolved target.
//
// Optional feature macro: PC_MISALIGN_CHK_EN
//   When defined, a flush to a target with target[1:0] != 0 raises a sticky
//   misalign flag and stops issuing fetches until reset. When undefined,
//   misalign is tied low and targets are used as-is.
//
// Ports
//   clk          core clock
//   reset        asynchronous, active-low reset
//   branch_ctl   {flush, pcSelect} redirect control from the branch check
//   br_pc        PC of the resolving branch/jump
//   br_imm       sign-extended immediate of that instruction
//   br_rs1       forwarded rs1 value (jalr base)
//   ireq_valid   fetch request valid
//   ireq_addr    fetch address
//   iresp_valid  fetch response valid (completes the outstanding request)
//   iresp_instr  fetched instruction
//   if_stall     downstream cannot accept the IF output this cycle
//   if_valid     IF output valid
//   if_pc        PC of the IF output
//   if_instr     instruction of the IF output
//   squash       combinational copy of branch_ctl.flush
//   misalign     sticky misaligned-target flag
//   fsm_state    current FSM state (S_FETCH=0, S_DROP=1, S_HOLD=2)
//
// Handshakes
//   ibus: a request is outstanding while ireq_valid=1; ireq_addr is held stable
//   until iresp_valid completes it (response may arrive in the issue cycle).
//   IF output: a word transfers on a rising edge where if_valid=1 and
//   if_stall=0; while if_valid=1 and if_stall=1 the if_* outputs hold.
// -----------------------------------------------------------------------------
package pc_redirect_pkg;
    typedef enum logic [1:0] {
        PC_From_add4    = 2'd0,
        PC_From_add_imm = 2'd1,
        PC_From_jalr    = 2'd2
    } pc_sel_t;

    typedef struct packed {
        logic    flush;
        pc_sel_t pcSelect;
    } branch_data_t;
endpackage

module pc_redirect_unit
    import pc_redirect_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  branch_data_t branch_ctl,
    input  logic [63:0]  br_pc,
    input  logic [63:0]  br_imm,
    input  logic [63:0]  br_rs1,
    output logic         ireq_valid,
    output logic [63:0]  ireq_addr,
    input  logic         iresp_valid,
    input  logic [31:0]  iresp_instr,
    input  logic         if_stall,
    output logic         if_valid,
    output logic [63:0]  if_pc,
    output logic [31:0]  if_instr,
    output logic         squash,
    output logic         misalign,
    output logic [1:0]   fsm_state
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DROP  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q;
    logic [63:0] hold_pc;
    logic [31:0] hold_instr;
    logic        req_en;       // low for the first cycle after reset release
    logic        misalign_q;
    logic        flush;
    logic        outstanding;
    logic        accept;
    logic [63:0] target;
    logic [63:0] jalr_sum;

    assign flush  = branch_ctl.flush;
    assign squash = flush;

    // Redirect target; only consumed when flush=1.
    always_comb begin
        jalr_sum = br_rs1 + br_imm;
        target   = br_pc + 64'd4;
        case (branch_ctl.pcSelect)
            PC_From_add_imm: target = br_pc + br_imm;
            PC_From_jalr:    target = jalr_sum & ~64'h1;
            default:         target = br_pc + 64'd4;
        endcase
    end

    // A response can only complete a request that is actually on the bus, so
    // a stray iresp_valid right after reset is ignored.
    assign accept      = ireq_valid && iresp_valid;
    assign outstanding = ireq_valid || (state_q == S_DROP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_en <= 1'b0;
        end else begin
            req_en <= 1'b1;
        end
    end

`ifdef PC_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (flush && (target[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end
`else
    assign misalign_q = 1'b0;
`endif

    assign misalign = misalign_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            // A request still in flight must be drained before refetching;
            // if its response lands in the flush cycle it is simply dropped.
            state_d = (outstanding && !iresp_valid) ? S_DROP : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: if (accept && if_valid && if_stall) state_d = S_HOLD;
                S_DROP:  if (iresp_valid)                    state_d = S_FETCH;
                S_HOLD:  if (!if_stall)                      state_d = S_FETCH;
                default:                                     state_d = S_FETCH;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        ireq_valid = (state_q == S_FETCH) && req_en && !misalign_q;
        ireq_addr  = pc_q;
        fsm_state  = state_q;
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            if_valid   <= 1'b0;
            if_pc      <= 64'd0;
            if_instr   <= 32'd0;
            hold_pc    <= 64'd0;
            hold_instr <= 32'd0;
        end else if (flush) begin
            pc_q       <= target;
            if_valid   <= 1'b0;
            hold_pc    <= 64'd0;
            hold_instr <= 32'd0;
        end else begin
            // Consumed output goes invalid unless new data replaces it below.
            if (if_valid && !if_stall) begin
                if_valid <= 1'b0;
            end
            case (state_q)
                S_FETCH: begin
                    if (accept) begin
                        pc_q <= pc_q + 64'd4;
                        if (!(if_valid && if_stall)) begin
                            if_valid <= 1'b1;
                            if_pc    <= pc_q;
                            if_instr <= iresp_instr;
                        end else begin
                            hold_pc    <= pc_q;
                            hold_instr <= iresp_instr;
                        end
                    end
                end
                S_HOLD: begin
                    if (!if_stall) begin
                        if_valid <= 1'b1;
                        if_pc    <= hold_pc;
                        if_instr <= hold_instr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_redirect_unit.sv
module tb_pc_redirect_unit;
    import pc_redirect_pkg::*;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    branch_data_t branch_ctl;
    logic [63:0]  br_pc, br_imm, br_rs1;
    logic         ireq_valid;
    logic [63:0]  ireq_addr;
    logic         iresp_valid;
    logic [31:0]  iresp_instr;
    logic         if_stall;
    logic         if_valid;
    logic [63:0]  if_pc;
    logic [31:0]  if_instr;
    logic         squash;
    logic         misalign;
    logic [1:0]   fsm_state;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk         (clk),
        .reset       (reset),
        .branch_ctl  (branch_ctl),
        .br_pc       (br_pc),
        .br_imm      (br_imm),
        .br_rs1      (br_rs1),
        .ireq_valid  (ireq_valid),
        .ireq_addr   (ireq_addr),
        .iresp_valid (iresp_valid),
        .iresp_instr (iresp_instr),
        .if_stall    (if_stall),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .squash      (squash),
        .misalign    (misalign),
        .fsm_state   (fsm_state)
    );

    // ---------------- scoreboard ----------------
    int          total = 0;
    int          bad = 0;
    logic [95:0] exp_q[$];
    logic [95:0] mon_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Monitor: every word accepted downstream must match the queue head.
    always @(negedge clk) begin
        if (reset && if_valid && !if_stall) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL if_out: got pc %h instr %h want nothing", if_pc, if_instr);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({if_pc, if_instr} !== mon_exp) begin
                    bad++;
                    $display("FAIL if_out: got pc %h instr %h want pc %h instr %h",
                             if_pc, if_instr, mon_exp[95:32], mon_exp[31:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Request visible now; respond one cycle later; return in the cycle after.
    task automatic fetch1(input logic [63:0] addr, input logic [31:0] ins);
        check_bit("req_valid_issue", ireq_valid, 1'b1);
        check("req_addr_issue", ireq_addr, addr);
        tick();
        check("req_addr_stable", ireq_addr, addr);
        iresp_valid = 1'b1;
        iresp_instr = ins;
        exp_q.push_back({addr, ins});
        tick();
        iresp_valid = 1'b0;
    endtask

    task automatic do_flush(input pc_sel_t sel, input logic [63:0] pc,
                            input logic [63:0] imm, input logic [63:0] rs1);
        branch_ctl = '{flush: 1'b1, pcSelect: sel};
        br_pc      = pc;
        br_imm     = imm;
        br_rs1     = rs1;
        #1;
        check_bit("squash_high", squash, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        branch_ctl  = '0;
        br_pc       = '0;
        br_imm      = '0;
        br_rs1      = '0;
        iresp_valid = 1'b0;
        iresp_instr = '0;
        if_stall    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_bit("rst_ireq_valid", ireq_valid, 1'b0);
        check_bit("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc", if_pc, 64'd0);
        check("rst_if_instr", {32'd0, if_instr}, 64'd0);
        check_bit("rst_misalign", misalign, 1'b0);
        check_bit("rst_squash", squash, 1'b0);

        // Release reset; a stray response in the first cycle must be ignored.
        reset       = 1'b1;
        iresp_valid = 1'b1;
        iresp_instr = 32'hBAD0_0000;
        #1;
        check_bit("first_cycle_no_req", ireq_valid, 1'b0);
        tick();
        iresp_valid = 1'b0;

        // 1: streaming fetch
        fetch1(64'h8000_0000, 32'h0000_0A00);
        fetch1(64'h8000_0004, 32'h0000_0A01);
        fetch1(64'h8000_0008, 32'h0000_0A02);
        check_bit("stream_if_valid", if_valid, 1'b1);
        tick();
        check_bit("if_valid_drop", if_valid, 1'b0);
        check("next_req_addr", ireq_addr, 64'h8000_000C);

        // 4: stall 3 cycles while two responses return
        if_stall    = 1'b1;
        iresp_valid = 1'b1;
        iresp_instr = 32'h0000_0B00;
        exp_q.push_back({64'h8000_000C, 32'h0000_0B00});
        tick();
        check_bit("stall_if_valid", if_valid, 1'b1);
        check("stall_if_pc", if_pc, 64'h8000_000C);
        check("stall_second_addr", ireq_addr, 64'h8000_0010);
        iresp_instr = 32'h0000_0B01;
        exp_q.push_back({64'h8000_0010, 32'h0000_0B01});
        tick();
        iresp_valid = 1'b0;
        check_bit("hold_no_req", ireq_valid, 1'b0);
        check("hold_state", {62'd0, fsm_state}, 64'd2);
        check("hold_if_pc", if_pc, 64'h8000_000C);
        tick();
        if_stall = 1'b0;
        #1;
        check_bit("hold_no_req_release", ireq_valid, 1'b0);
        tick();
        check("hold_out_pc", if_pc, 64'h8000_0010);
        check_bit("resume_req_valid", ireq_valid, 1'b1);
        check("resume_req_addr", ireq_addr, 64'h8000_0014);
        tick();
        check_bit("post_hold_drop", if_valid, 1'b0);

        // 2: flush with no fetch outstanding (from S_HOLD, stalled)
        if_stall    = 1'b1;
        iresp_valid = 1'b1;
        iresp_instr = 32'h0000_0C00;
        tick();
        iresp_instr = 32'h0000_0C01;
        tick();
        iresp_valid = 1'b0;
        check_bit("pre_flush_no_req", ireq_valid, 1'b0);
        do_flush(PC_From_add_imm, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);
        tick();
        branch_ctl = '0;
        if_stall   = 1'b0;
        #1;
        check_bit("squash_low", squash, 1'b0);
        check_bit("flush_if_valid", if_valid, 1'b0);
        check_bit("flush_req_valid", ireq_valid, 1'b1);
        check("flush_req_addr", ireq_addr, 64'h8000_0000);

        // 3: jalr flush with a fetch outstanding -> drop stale response
        do_flush(PC_From_jalr, 64'd0, 64'h10, 64'h8000_1001);
        tick();
        branch_ctl = '0;
        #1;
        check_bit("drop_no_req", ireq_valid, 1'b0);
        check("drop_state", {62'd0, fsm_state}, 64'd1);
        tick();
        iresp_valid = 1'b1;
        iresp_instr = 32'hDEAD_0000;
        tick();
        iresp_valid = 1'b0;
        check_bit("drop_if_valid", if_valid, 1'b0);
        check_bit("jalr_req_valid", ireq_valid, 1'b1);
        check("jalr_req_addr", ireq_addr, 64'h8000_1010);

        // 5: flush + response in the same cycle, with stall
        iresp_valid = 1'b1;
        iresp_instr = 32'h0000_0F00;
        if_stall    = 1'b1;
        tick();
        check_bit("f5_if_valid", if_valid, 1'b1);
        check("f5_if_pc", if_pc, 64'h8000_1010);
        check("f5_req_addr", ireq_addr, 64'h8000_1014);
        iresp_instr = 32'h0000_0F01;
        do_flush(PC_From_add_imm, 64'h8000_2000, 64'h100, 64'd0);
        tick();
        branch_ctl  = '0;
        iresp_valid = 1'b0;
        if_stall    = 1'b0;
        #1;
        check_bit("f5_if_valid_clr", if_valid, 1'b0);
        check("f5_state", {62'd0, fsm_state}, 64'd0);
        fetch1(64'h8000_2100, 32'h0000_0E00);
        tick();

        // 6: flush to a misaligned target while a fetch is outstanding
        do_flush(PC_From_add_imm, 64'h8000_0000, 64'h2, 64'd0);
        tick();
        branch_ctl = '0;
        #1;
`ifdef PC_MISALIGN_CHK_EN
        check_bit("mis_flag", misalign, 1'b1);
`else
        check_bit("mis_flag", misalign, 1'b0);
`endif
        check_bit("mis_drop_no_req", ireq_valid, 1'b0);
        tick();
        iresp_valid = 1'b1;
        iresp_instr = 32'hDEAD_0001;
        tick();
        iresp_valid = 1'b0;
        #1;
`ifdef PC_MISALIGN_CHK_EN
        check_bit("mis_no_req", ireq_valid, 1'b0);
        check_bit("mis_sticky", misalign, 1'b1);
        repeat (3) tick();
        check_bit("mis_no_req_later", ireq_valid, 1'b0);
`else
        check_bit("mis_req_valid", ireq_valid, 1'b1);
        check("mis_req_addr", ireq_addr, 64'h8000_0002);
        check_bit("mis_clear", misalign, 1'b0);
`endif

        repeat (2) tick();
        check("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
